// File: rtl/cic_ctrl.sv
// cic_ctrl: PDM bit clock, decimation timing and frame readout for the CIC bank.
// Define CIC_CTRL_OVF_CNT_EN to build the 16-bit dropped-frame counter.
module cic_ctrl #(
  parameter int NUM_CH   = 16,
  parameter int WIDTH    = 24,
  parameter int CLK_DIV  = 32,
  parameter int DEC_RATE = 64,
  parameter int WARMUP   = 3,
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH*WIDTH-1:0] cic_in,
  output logic                    mic_clk,
  output logic                    pdm_ce,
  output logic                    dec_stb,
  output logic [WIDTH-1:0]        out_data,
  output logic [CW-1:0]           out_ch,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic [15:0]             ovf_count
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int RW = (DEC_RATE > 1) ? $clog2(DEC_RATE) : 1;
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [RW-1:0] DEC_LAST = RW'(DEC_RATE - 1);
  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  logic [DW-1:0]    div_cnt;
  logic [RW-1:0]    dec_cnt;
  logic [WW-1:0]    warm_cnt;
  logic             cap;
  logic             warm_cap;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    ch;
  logic [CW-1:0]    ch_n;
  logic             load;
  logic             drop;
  logic             ovf_n;
  logic             hs;
  logic             last_hs;

  logic [WIDTH-1:0] bank [NUM_CH];

  assign pdm_ce  = enable && (div_cnt == DIV_LAST);
  assign dec_stb = pdm_ce && (dec_cnt == DEC_LAST);

  // Bit-clock divider; held at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Registered mic clock: high for the upper half of the divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      mic_clk <= 1'b0;
    end else begin
      mic_clk <= enable && (div_cnt >= DIV_HALF);
    end
  end

  // PDM bits per decimated sample.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      dec_cnt <= '0;
    end else if (pdm_ce) begin
      if (dec_cnt == DEC_LAST) begin
        dec_cnt <= '0;
      end else begin
        dec_cnt <= dec_cnt + 1'b1;
      end
    end
  end

  // Capture one cycle after the differentiator strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= 1'b0;
    end else begin
      cap <= dec_stb;
    end
  end

  // Counts warm-up frames after enable rises, saturating when warm.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      warm_cnt <= '0;
    end else if (cap && (warm_cnt != WARM_MAX)) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign warm_cap = cap && enable && (warm_cnt == WARM_MAX);

  assign hs      = (state == STREAM) && out_ready;
  assign last_hs = hs && (ch == CH_LAST);

  // Readout FSM: next state, channel pointer, frame load and drop.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    load    = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (warm_cap) begin
          load    = 1'b1;
          ch_n    = '0;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (last_hs && warm_cap) begin
          load = 1'b1;
          ch_n = '0;
        end else if (last_hs) begin
          ch_n    = '0;
          state_n = IDLE;
        end else begin
          if (hs) begin
            ch_n = ch + 1'b1;
          end
          if (warm_cap) begin
            drop = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        ch_n    = '0;
      end
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    ovf_n = ovf;
    if (drop) begin
      ovf_n = 1'b1;
    end else if (ovf_clr) begin
      ovf_n = 1'b0;
    end
  end

  // FSM state, channel pointer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      ovf   <= ovf_n;
    end
  end

  // Holding bank; only written on an accepted frame, never on a drop.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NUM_CH; k++) begin
        bank[k] <= cic_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stream outputs come straight from registers, zero outside a frame.
  always_comb begin
    out_valid = (state == STREAM);
    out_data  = '0;
    out_ch    = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = bank[ch];
      out_ch   = ch;
      out_last = (ch == CH_LAST);
    end
  end

`ifdef CIC_CTRL_OVF_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating dropped-frame counter; a drop during clear counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign ovf_count = drop_cnt;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_cic_ctrl.sv
// tb_cic_ctrl: randomized bench for cic_ctrl against a cycle-count/queue model.
// Optional CIC_CTRL_OVF_CNT_EN selects the expected dropped-frame count.
module tb_cic_ctrl;

  localparam int NUM_CH   = 4;
  localparam int WIDTH    = 24;
  localparam int CLK_DIV  = 4;
  localparam int DEC_RATE = 4;
  localparam int WARMUP   = 3;
  localparam int CW       = $clog2(NUM_CH);
  localparam int FRAME    = CLK_DIV * DEC_RATE;
`ifdef CIC_CTRL_OVF_CNT_EN
  localparam int DROP_CNT = 1;
`else
  localparam int DROP_CNT = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic [NUM_CH*WIDTH-1:0] cic_in;
  logic                    mic_clk;
  logic                    pdm_ce;
  logic                    dec_stb;
  logic [WIDTH-1:0]        out_data;
  logic [CW-1:0]           out_ch;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic                    ovf;
  logic                    ovf_clr;
  logic [15:0]             ovf_count;

  int total = 0;
  int bad   = 0;

  int c     = 0;
  int caps  = 0;
  bit m_ovf = 0;
  int m_cnt = 0;
  logic [WIDTH-1:0] q[$];

  cic_ctrl #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .CLK_DIV(CLK_DIV),
    .DEC_RATE(DEC_RATE), .WARMUP(WARMUP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cic_in(cic_in),
    .mic_clk(mic_clk), .pdm_ce(pdm_ce), .dec_stb(dec_stb),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    c     = 0;
    caps  = 0;
    m_ovf = 0;
    m_cnt = 0;
  endtask

  task automatic set_pattern();
    for (int k = 0; k < NUM_CH; k++) begin
      cic_in[k*WIDTH +: WIDTH] = WIDTH'(32'h100 + k);
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < NUM_CH; k++) begin
      cic_in[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic run_cycle();
    bit e_pdm, e_dec, e_mic, e_val, hs, cap, drop;
    c = enable ? c + 1 : 0;
    e_pdm = enable && c > 0 && (c % CLK_DIV) == 0;
    e_dec = enable && c > 0 && (c % FRAME) == 0;
    e_mic = enable && c >= 2 && ((c - 2) % CLK_DIV) >= CLK_DIV / 2;
    e_val = q.size() > 0;
    @(negedge clk);
    total++;
    if (pdm_ce !== e_pdm) begin
      bad++;
      $display("FAIL pdm_ce c=%0d got=%b want=%b", c, pdm_ce, e_pdm);
    end
    total++;
    if (dec_stb !== e_dec) begin
      bad++;
      $display("FAIL dec_stb c=%0d got=%b want=%b", c, dec_stb, e_dec);
    end
    total++;
    if (mic_clk !== e_mic) begin
      bad++;
      $display("FAIL mic_clk c=%0d got=%b want=%b", c, mic_clk, e_mic);
    end
    total++;
    if (out_valid !== e_val) begin
      bad++;
      $display("FAIL out_valid c=%0d got=%b want=%b", c, out_valid, e_val);
    end
    if (e_val) begin
      total++;
      if (out_data !== q[0]) begin
        bad++;
        $display("FAIL out_data c=%0d got=%h want=%h", c, out_data, q[0]);
      end
      total++;
      if (out_ch !== CW'(NUM_CH - q.size())) begin
        bad++;
        $display("FAIL out_ch c=%0d got=%0d want=%0d", c, out_ch,
                 NUM_CH - q.size());
      end
      total++;
      if (out_last !== (q.size() == 1)) begin
        bad++;
        $display("FAIL out_last c=%0d got=%b want=%b", c, out_last,
                 q.size() == 1);
      end
    end
    total++;
    if (ovf !== m_ovf) begin
      bad++;
      $display("FAIL ovf c=%0d got=%b want=%b", c, ovf, m_ovf);
    end
    total++;
    if (ovf_count !== 16'(m_cnt)) begin
      bad++;
      $display("FAIL ovf_count c=%0d got=%0d want=%0d", c, ovf_count, m_cnt);
    end
    hs = e_val && (out_ready === 1'b1);
    if (hs) void'(q.pop_front());
    cap  = enable && c > 1 && ((c - 1) % FRAME) == 0;
    drop = 0;
    if (cap) begin
      caps++;
      if (caps > WARMUP) begin
        if (q.size() == 0) begin
          for (int k = 0; k < NUM_CH; k++) begin
            q.push_back(cic_in[k*WIDTH +: WIDTH]);
          end
        end else begin
          drop = 1;
        end
      end
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
`ifdef CIC_CTRL_OVF_CNT_EN
    if (ovf_clr) m_cnt = drop ? 1 : 0;
    else if (drop && m_cnt < 65535) m_cnt++;
`endif
    @(posedge clk);
    #1;
  endtask

  // Drain with ready high, then park mid-period with nothing pending.
  task automatic align_idle();
    int n = 0;
    out_ready = 1'b1;
    while (!(q.size() == 0 && ((c - 1) % FRAME) == FRAME / 2) && n < 80) begin
      run_cycle();
      n++;
    end
    total++;
    if (n >= 80) begin
      bad++;
      $display("FAIL align_timeout got=%0d want=<80", n);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    cic_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    total++;
    if ({mic_clk, pdm_ce, dec_stb, out_last, out_valid, ovf} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {mic_clk, pdm_ce, dec_stb, out_last, out_valid, ovf});
    end
    total++;
    if (out_data !== '0 || out_ch !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%0d want=0/0", out_data, out_ch);
    end
    total++;
    if (ovf_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", ovf_count);
    end
    run_cycle();
  endtask

  task automatic test_clocks();
    int pdm_at[$];
    int dec_at[$];
    int mic_hi = 0;
    model_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    set_pattern();
    for (int i = 0; i < 20; i++) begin
      if (pdm_ce) pdm_at.push_back(c + 1);
      if (dec_stb) dec_at.push_back(c + 1);
      if (mic_clk) mic_hi++;
      run_cycle();
    end
    total++;
    if (pdm_at.size() != 5) begin
      bad++;
      $display("FAIL pdm_count got=%0d want=5", pdm_at.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (pdm_at[i] != 4 * (i + 1)) begin
          bad++;
          $display("FAIL pdm_cycle got=%0d want=%0d", pdm_at[i], 4 * (i + 1));
        end
      end
    end
    total++;
    if (dec_at.size() != 1 || dec_at[0] != 16) begin
      bad++;
      $display("FAIL dec_cycle got=%0d pulses want=1 at 16", dec_at.size());
    end
    total++;
    if (mic_hi != 9) begin
      bad++;
      $display("FAIL mic_high got=%0d want=9", mic_hi);
    end
  endtask

  task automatic test_first_frame();
    int n_at[$];
    int got_ch[$];
    logic [WIDTH-1:0] got_d[$];
    bit got_l[$];
    while (c < 75) begin
      if (out_valid) begin
        n_at.push_back(c + 1);
        got_ch.push_back(int'(out_ch));
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      run_cycle();
    end
    total++;
    if (n_at.size() != NUM_CH) begin
      bad++;
      $display("FAIL first_words got=%0d want=%0d", n_at.size(), NUM_CH);
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        total++;
        if (n_at[k] != 66 + k || got_ch[k] != k ||
            got_d[k] !== WIDTH'(32'h100 + k) || got_l[k] != (k == 3)) begin
          bad++;
          $display("FAIL first_word%0d got=c%0d ch%0d %h l%b want=c%0d ch%0d %h l%b",
                   k, n_at[k], got_ch[k], got_d[k], got_l[k],
                   66 + k, k, 32'h100 + k, k == 3);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit pv = 0;
    bit pr = 0;
    logic [WIDTH-1:0] pd = '0;
    logic [CW-1:0] pc = '0;
    bit pl = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (pv && !pr) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== pd || out_ch !== pc ||
            out_last !== pl) begin
          bad++;
          $display("FAIL stall_hold got=%b %h %0d want=1 %h %0d",
                   out_valid, out_data, out_ch, pd, pc);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      set_random();
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pc = out_ch;
      pl = out_last;
      run_cycle();
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    ovf_clr   = 1'b1;
    run_cycle();
    ovf_clr = 1'b0;
    align_idle();
    set_random();
    out_ready = 1'b0;
    repeat (2 * FRAME) run_cycle();
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got=%b want=1", ovf);
    end
    total++;
    if (ovf_count !== 16'(DROP_CNT)) begin
      bad++;
      $display("FAIL ovf_cnt got=%0d want=%0d", ovf_count, DROP_CNT);
    end
    total++;
    if (out_valid !== 1'b1 || out_ch !== '0) begin
      bad++;
      $display("FAIL ovf_held got=%b/%0d want=1/0", out_valid, out_ch);
    end
    ovf_clr = 1'b1;
    run_cycle();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0 || ovf_count !== 16'd0) begin
      bad++;
      $display("FAIL ovf_clr got=%b/%0d want=0/0", ovf, ovf_count);
    end
    align_idle();
  endtask

  task automatic test_back_to_back();
    int ph;
    logic [WIDTH-1:0] ch0;
    align_idle();
    set_random();
    ch0 = cic_in[0 +: WIDTH];
    for (int i = 0; i < 24; i++) begin
      ph = c % FRAME;
      out_ready = (ph >= 13 || ph == 0);
      run_cycle();
    end
    total++;
    if (out_valid !== 1'b1 || out_ch !== '0 || out_data !== ch0) begin
      bad++;
      $display("FAIL b2b_restart got=%b ch%0d %h want=1 ch0 %h",
               out_valid, out_ch, out_data, ch0);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ovf got=%b want=0", ovf);
    end
    out_ready = 1'b1;
    repeat (2) run_cycle();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int first = -1;
    int words = 0;
    out_ready = 1'b1;
    while (!(out_valid && out_ch == 2) && n < 40) begin
      run_cycle();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL mid_find got=%0d want=<40", n);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    total++;
    if ({out_valid, out_last, mic_clk, pdm_ce, dec_stb, ovf} !== 6'b0 ||
        out_data !== '0 || out_ch !== '0) begin
      bad++;
      $display("FAIL mid_rst got=%b %h %0d want=0 0 0",
               {out_valid, out_last, mic_clk, pdm_ce, dec_stb, ovf},
               out_data, out_ch);
    end
    while (c < 75) begin
      if (out_valid) begin
        if (first < 0) first = c + 1;
        words++;
      end
      set_random();
      run_cycle();
    end
    total++;
    if (first != 66 || words != NUM_CH) begin
      bad++;
      $display("FAIL mid_rewarm got=c%0d/%0d want=c66/%0d", first, words, NUM_CH);
    end
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_first_frame();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
